// File: rtl/uart_send_engine.sv
// uart_send_engine: buffers bytes posted by BusControl in a small circular
// FIFO and serialises each one as 8N1 (LSB first) on a registered TXD line.
// Back-to-back frames are contiguous: the next byte is popped in the same
// cycle the stop bit ends.
module uart_send_engine #(
    parameter int CLK_DIV    = 217,
    parameter int FIFO_ALOG2 = 2
) (
    input  logic       MCLK_IN,
    input  logic       RESET_IN,
    input  logic       UART_SEND_TRIGGER_IN,
    input  logic [7:0] UART_SEND_BYTE_IN,
    output logic       UART_SEND_BUSY,
    output logic       UART_SEND_OVERRUN,
    output logic       UART_TX_ACTIVE,
    output logic       TXD
);

    localparam int DEPTH = 2 ** FIFO_ALOG2;
    localparam logic [FIFO_ALOG2:0]   CNT_FULL  = (FIFO_ALOG2 + 1)'(DEPTH);
    localparam logic [FIFO_ALOG2:0]   CNT_ZERO  = (FIFO_ALOG2 + 1)'(0);
    localparam logic [FIFO_ALOG2:0]   CNT_ONE   = (FIFO_ALOG2 + 1)'(1);
    localparam logic [FIFO_ALOG2-1:0] PTR_ZERO  = FIFO_ALOG2'(0);
    localparam logic [FIFO_ALOG2-1:0] PTR_ONE   = FIFO_ALOG2'(1);
    localparam logic [15:0]           BAUD_LAST = 16'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t                state_r, state_nxt_s;
    logic [15:0]           baud_cnt_r, baud_nxt_s;
    logic [2:0]            bit_idx_r, bit_idx_nxt_s;
    logic [7:0]            shreg_r, shreg_nxt_s;
    logic [7:0]            fifo_mem_r [DEPTH];
    logic [FIFO_ALOG2-1:0] wr_ptr_r, rd_ptr_r;
    logic [FIFO_ALOG2:0]   count_r, count_nxt_s;
    logic                  trig_q_r;
    logic                  txd_r, busy_r, overrun_r, active_r;
    logic                  write_s, pop_s, accept_s, drop_s, baud_end_s, txd_nxt_s;

    // One write per trigger assertion; a write with a full FIFO only
    // succeeds when the FSM frees a slot in the same cycle.
    assign write_s    = UART_SEND_TRIGGER_IN & ~trig_q_r;
    assign accept_s   = write_s & ((count_r != CNT_FULL) | pop_s);
    assign drop_s     = write_s & ~accept_s;
    assign baud_end_s = (baud_cnt_r == BAUD_LAST);

    // Frame sequencer: next state, baud/bit counters, shift register and pop.
    always_comb begin
        state_nxt_s   = state_r;
        baud_nxt_s    = baud_cnt_r;
        bit_idx_nxt_s = bit_idx_r;
        shreg_nxt_s   = shreg_r;
        pop_s         = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (count_r != CNT_ZERO) begin
                    pop_s       = 1'b1;
                    shreg_nxt_s = fifo_mem_r[rd_ptr_r];
                    baud_nxt_s  = 16'd0;
                    state_nxt_s = ST_START;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (baud_end_s) begin
                    baud_nxt_s    = 16'd0;
                    bit_idx_nxt_s = 3'd0;
                    state_nxt_s   = ST_DATA;
                end else begin
                    baud_nxt_s = baud_cnt_r + 16'd1;
                end
            end
            ST_DATA: begin
                if (baud_end_s) begin
                    baud_nxt_s    = 16'd0;
                    shreg_nxt_s   = {1'b0, shreg_r[7:1]};
                    bit_idx_nxt_s = bit_idx_r + 3'd1;
                    if (bit_idx_r == 3'd7) begin
                        state_nxt_s = ST_STOP;
                    end else begin
                        state_nxt_s = ST_DATA;
                    end
                end else begin
                    baud_nxt_s = baud_cnt_r + 16'd1;
                end
            end
            ST_STOP: begin
                if (baud_end_s) begin
                    baud_nxt_s = 16'd0;
                    if (count_r != CNT_ZERO) begin
                        pop_s       = 1'b1;
                        shreg_nxt_s = fifo_mem_r[rd_ptr_r];
                        state_nxt_s = ST_START;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    baud_nxt_s = baud_cnt_r + 16'd1;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                baud_nxt_s  = 16'd0;
            end
        endcase
    end

    // Line level for the current state; registered below so TXD is glitch-free.
    always_comb begin
        txd_nxt_s = 1'b1;
        case (state_r)
            ST_IDLE:  txd_nxt_s = 1'b1;
            ST_START: txd_nxt_s = 1'b0;
            ST_DATA:  txd_nxt_s = shreg_r[0];
            ST_STOP:  txd_nxt_s = 1'b1;
            default:  txd_nxt_s = 1'b1;
        endcase
    end

    // FIFO occupancy after this cycle's accepted write and/or pop.
    always_comb begin
        count_nxt_s = count_r;
        if (accept_s && !pop_s) begin
            count_nxt_s = count_r + CNT_ONE;
        end else if (!accept_s && pop_s) begin
            count_nxt_s = count_r - CNT_ONE;
        end else begin
            count_nxt_s = count_r;
        end
    end

    // FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge MCLK_IN) begin
        if (accept_s) begin
            fifo_mem_r[wr_ptr_r] <= UART_SEND_BYTE_IN;
        end
    end

    // State, pointers, trigger history and registered status outputs.
    always_ff @(posedge MCLK_IN) begin
        if (RESET_IN) begin
            state_r    <= ST_IDLE;
            baud_cnt_r <= 16'd0;
            bit_idx_r  <= 3'd0;
            shreg_r    <= 8'd0;
            wr_ptr_r   <= PTR_ZERO;
            rd_ptr_r   <= PTR_ZERO;
            count_r    <= CNT_ZERO;
            trig_q_r   <= 1'b1;
            txd_r      <= 1'b1;
            busy_r     <= 1'b0;
            overrun_r  <= 1'b0;
            active_r   <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            baud_cnt_r <= baud_nxt_s;
            bit_idx_r  <= bit_idx_nxt_s;
            shreg_r    <= shreg_nxt_s;
            if (accept_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (pop_s)    rd_ptr_r <= rd_ptr_r + PTR_ONE;
            count_r    <= count_nxt_s;
            trig_q_r   <= UART_SEND_TRIGGER_IN;
            txd_r      <= txd_nxt_s;
            busy_r     <= (count_nxt_s == CNT_FULL);
            overrun_r  <= overrun_r | drop_s;
            active_r   <= (count_nxt_s != CNT_ZERO) | (state_nxt_s != ST_IDLE);
        end
    end

    assign TXD               = txd_r;
    assign UART_SEND_BUSY    = busy_r;
    assign UART_SEND_OVERRUN = overrun_r;
    assign UART_TX_ACTIVE    = active_r;

endmodule

// File: tb/tb_uart_send_engine.sv
// Bench for uart_send_engine: directed scenarios plus random traffic, every
// cycle compared against a queue-based model of bytes and frame timing.
module tb_uart_send_engine;

    localparam int DIV   = 4;
    localparam int ALOG2 = 2;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * DIV;

    logic       clk = 1'b0;
    logic       rst;
    logic       trig;
    logic [7:0] tx_byte;
    logic       busy, overrun, active, txd;

    // Reference model state
    logic [7:0] m_q[$];
    bit         m_cur;
    int         m_el;
    logic [7:0] m_byte;
    bit         m_hist;
    logic       exp_txd, exp_busy, exp_ovr, exp_act;

    int checks = 0;
    int passes = 0;
    int cyc    = 0;

    uart_send_engine #(.CLK_DIV(DIV), .FIFO_ALOG2(ALOG2)) dut (
        .MCLK_IN              (clk),
        .RESET_IN             (rst),
        .UART_SEND_TRIGGER_IN (trig),
        .UART_SEND_BYTE_IN    (tx_byte),
        .UART_SEND_BUSY       (busy),
        .UART_SEND_OVERRUN    (overrun),
        .UART_TX_ACTIVE       (active),
        .TXD                  (txd)
    );

    always #5 clk = ~clk;

    // Line level e cycles into a frame: start, 8 data bits LSB first, stop.
    function automatic logic frame_bit(input logic [7:0] b, input int e);
        int k;
        k = e / DIV;
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) passes++;
        else $error("FAIL %s observed=%b expected=%b cycle=%0d", tag, obs, expv, cyc);
    endtask

    // Advance one clock, update the model, then compare all outputs.
    task automatic step();
        bit wr, pop, accept;
        @(posedge clk);
        cyc++;
        if (rst) begin
            m_q.delete();
            m_cur = 0; m_el = 0; m_hist = 1;
            exp_txd = 1'b1; exp_busy = 1'b0; exp_ovr = 1'b0; exp_act = 1'b0;
        end else begin
            wr     = trig && !m_hist;
            m_hist = trig;
            exp_txd = m_cur ? frame_bit(m_byte, m_el) : 1'b1;
            if (m_cur) begin
                m_el++;
                if (m_el == FRAME) m_cur = 0;
            end
            pop    = !m_cur && (m_q.size() != 0);
            accept = wr && ((m_q.size() < DEPTH) || pop);
            if (pop) begin
                m_byte = m_q.pop_front();
                m_cur  = 1; m_el = 0;
            end
            if (accept) m_q.push_back(tx_byte);
            if (wr && !accept) exp_ovr = 1'b1;
            exp_busy = (m_q.size() == DEPTH);
            exp_act  = (m_q.size() != 0) || m_cur;
        end
        #1;
        chk("txd", txd, exp_txd);
        chk("busy", busy, exp_busy);
        chk("overrun", overrun, exp_ovr);
        chk("tx_active", active, exp_act);
    endtask

    task automatic write_byte(input logic [7:0] b);
        trig = 1'b1; tx_byte = b; step();
        trig = 1'b0; step();
    endtask

    task automatic do_reset();
        rst = 1'b1; trig = 1'b0; repeat (2) step();
        rst = 1'b0; step();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_act && n < 1000) begin step(); n++; end
        chk("wait_idle", active, 1'b0);
    endtask

    initial begin
        rst = 1'b1; trig = 1'b0; tx_byte = 8'h00;
        repeat (3) step();
        chk("reset_txd", txd, 1'b1);
        chk("reset_busy", busy, 1'b0);
        rst = 1'b0; step();

        // 1: single byte 0x55, TXD low two cycles after the write edge
        trig = 1'b1; tx_byte = 8'h55; step();
        chk("t1_txd_e0", txd, 1'b1);
        trig = 1'b0; step();
        chk("t1_txd_e1", txd, 1'b1);
        step();
        chk("t1_txd_e2", txd, 1'b0);
        wait_idle();
        repeat (5) step();

        // 2: trigger held 20 cycles gives exactly one frame
        trig = 1'b1; tx_byte = 8'hA3;
        repeat (20) step();
        trig = 1'b0;
        wait_idle();
        repeat (60) step();
        chk("t2_no_second", active, 1'b0);

        // 3: five writes fill the FIFO, sixth overruns
        for (int i = 1; i <= 5; i++) write_byte(8'(i));
        chk("t3_busy", busy, 1'b1);
        trig = 1'b1; tx_byte = 8'h06; step();
        chk("t3_overrun", overrun, 1'b1);
        trig = 1'b0;
        wait_idle();

        // 4: write into a full FIFO in the cycle the stop bit ends and a pop occurs
        do_reset();
        for (int i = 0; i < 5; i++) write_byte(8'h21 + 8'(i));
        begin
            int n;
            n = 0;
            while (!(m_cur && m_el == FRAME - 1 && m_q.size() == DEPTH) && n < 200) begin
                step(); n++;
            end
        end
        trig = 1'b1; tx_byte = 8'h77; step();
        chk("t4_busy", busy, 1'b1);
        chk("t4_no_overrun", overrun, 1'b0);
        trig = 1'b0;
        wait_idle();

        // 5: reset during data bit 3 of 0xFF with two bytes queued
        do_reset();
        write_byte(8'hFF);
        write_byte(8'hAA);
        write_byte(8'hBB);
        begin
            int n;
            n = 0;
            while (!(m_cur && m_byte == 8'hFF && m_el == 4 * DIV + 1) && n < 200) begin
                step(); n++;
            end
        end
        rst = 1'b1; step();
        chk("t5_txd", txd, 1'b1);
        chk("t5_busy", busy, 1'b0);
        chk("t5_active", active, 1'b0);
        chk("t5_overrun", overrun, 1'b0);
        rst = 1'b0;
        repeat (100) step();
        chk("t5_quiet", txd, 1'b1);

        // 6: nine bytes, each after the previous frame, wrap the pointers
        for (int i = 0; i < 9; i++) begin
            write_byte(8'h10 + 8'(i));
            wait_idle();
        end

        // Random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            trig    = ($urandom_range(0, 3) == 0);
            tx_byte = 8'($urandom);
            rst     = ($urandom_range(0, 499) == 0);
            step();
        end
        rst = 1'b0; trig = 1'b0;
        wait_idle();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
